// File: rtl/cordic_sched_pkg.sv
// Shared types and angle constants for the CORDIC request scheduler.
// Angles are degrees in Q16.16.
package cordic_sched_pkg;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] DEG90  = 32'd5898240;
  localparam logic [DATA_W-1:0] DEG180 = 32'd11796480;
  localparam logic [DATA_W-1:0] DEG270 = 32'd17694720;
  localparam logic [DATA_W-1:0] DEG360 = 32'd23592960;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    if (oh[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/cordic_scheduler_rr_arbiter4.sv
// Four-way combinational round-robin arbiter; the requester after `last`
// has highest priority and `last` itself has the lowest.
module rr_arbiter4
  import cordic_sched_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Time-shares one external CORDIC core among four requesters: arbitrates,
// folds the angle into [-90, 90] degrees, waits out the core latency, returns results.
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int CORE_LAT = 16,
  parameter int N_REQ    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [32*N_REQ-1:0]     req_angle,
  output logic [N_REQ-1:0]        gnt,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [1:0]              resp_id,
  output logic signed [31:0]      resp_cos,
  output logic signed [31:0]      resp_sin,
  output logic                    resp_err,
  output logic signed [31:0]      core_angle,
  input  logic signed [31:0]      core_cos,
  input  logic signed [31:0]      core_sin
);

  localparam logic [7:0] CNT_LOAD = 8'(CORE_LAT - 1);

  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x);
    if (x == 32'sh8000_0000) return 32'sh7FFF_FFFF;
    return -x;
  endfunction

  function automatic logic signed [31:0] apply_neg(input logic signed [31:0] x,
                                                   input logic neg);
    return neg ? sat_neg(x) : x;
  endfunction

  state_t state, state_nxt;

  logic [1:0]         last_ptr;
  logic [3:0]         win;
  logic [1:0]         win_idx;
  logic [31:0]        win_angle;
  logic               angle_bad;
  logic signed [31:0] fold_angle;
  logic               fold_neg;
  logic               grant_fire;
  logic [7:0]         cnt_p0;
  logic               neg_p0;

  rr_arbiter4 u_arb (
    .req  (req),
    .last (last_ptr),
    .gnt  (win)
  );

  // Grant decode and quadrant fold of the winning angle
  always_comb begin
    win_idx   = onehot_to_idx(win);
    win_angle = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) win_angle = req_angle[32*i +: 32];
    end
    angle_bad = (win_angle >= DEG360);
    if (win_angle <= DEG90) begin
      fold_angle = signed'(win_angle);
      fold_neg   = 1'b0;
    end else if (win_angle <= DEG270) begin
      fold_angle = signed'(win_angle - DEG180);
      fold_neg   = 1'b1;
    end else begin
      fold_angle = signed'(win_angle - DEG360);
      fold_neg   = 1'b0;
    end
    grant_fire = (state == ST_IDLE) && (|win) && !rst;
  end

  always_comb begin
    state_nxt  = state;
    gnt        = '0;
    resp_valid = (state == ST_RESP);
    case (state)
      ST_IDLE: begin
        if (grant_fire) begin
          gnt       = win;
          state_nxt = angle_bad ? ST_RESP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_p0 == 8'd0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p0: grant latches angle/id; core result captured when the counter expires
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_ptr   <= 2'd3;
      cnt_p0     <= '0;
      neg_p0     <= 1'b0;
      core_angle <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
      resp_cos   <= '0;
      resp_sin   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        last_ptr <= win_idx;
        resp_id  <= win_idx;
        if (angle_bad) begin
          resp_err <= 1'b1;
          resp_cos <= '0;
          resp_sin <= '0;
        end else begin
          resp_err   <= 1'b0;
          core_angle <= fold_angle;
          neg_p0     <= fold_neg;
          cnt_p0     <= CNT_LOAD;
        end
      end else if (state == ST_RUN) begin
        if (cnt_p0 == 8'd0) begin
          resp_cos <= apply_neg(core_cos, neg_p0);
          resp_sin <= apply_neg(core_sin, neg_p0);
        end else begin
          cnt_p0 <= cnt_p0 - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler with a CORE_LAT-deep core model
// returning fixed cos/sin values keyed by the folded angle.
module tb_cordic_scheduler;

  localparam int CORE_LAT = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         req;
  logic [127:0]       req_angle;
  logic [3:0]         gnt;
  logic               resp_valid;
  logic               resp_ready;
  logic [1:0]         resp_id;
  logic signed [31:0] resp_cos;
  logic signed [31:0] resp_sin;
  logic               resp_err;
  logic signed [31:0] core_angle;
  logic signed [31:0] core_cos;
  logic signed [31:0] core_sin;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_scheduler #(.CORE_LAT(CORE_LAT), .N_REQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_angle  (req_angle),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_cos   (resp_cos),
    .resp_sin   (resp_sin),
    .resp_err   (resp_err),
    .core_angle (core_angle),
    .core_cos   (core_cos),
    .core_sin   (core_sin)
  );

  // Core model: output reflects core_angle only after it has been held CORE_LAT cycles
  logic [31:0] pipe [0:CORE_LAT-2];
  always @(posedge clk) begin
    pipe[0] <= core_angle;
    for (int i = 1; i < CORE_LAT-1; i++) pipe[i] <= pipe[i-1];
  end

  function automatic logic [31:0] tab_cos(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0001_0000;
      32'h005A_0000: return 32'h0000_0000;
      32'h0040_2400: return 32'h8000_0000;
      default:       return 32'h0000_1111;
    endcase
  endfunction

  function automatic logic [31:0] tab_sin(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0000;
      32'h005A_0000: return 32'h0001_0000;
      32'h0040_2400: return 32'h0001_2345;
      default:       return 32'h0000_2222;
    endcase
  endfunction

  assign core_cos = tab_cos(pipe[CORE_LAT-2]);
  assign core_sin = tab_sin(pipe[CORE_LAT-2]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input int idx, input logic [31:0] ang,
                         input int exp_lat, input logic [31:0] exp_core,
                         input logic [31:0] exp_cos, input logic [31:0] exp_sin,
                         input logic exp_err);
    int n;
    req = '0;
    req[idx] = 1'b1;
    req_angle[32*idx +: 32] = ang;
    #1;
    check({tag, ".gnt"}, 32'(gnt), 32'(1 << idx));
    step();
    req = '0;
    n = 1;
    check({tag, ".core_angle"}, core_angle, exp_core);
    while (!resp_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(exp_lat));
    check({tag, ".resp_id"}, 32'(resp_id), 32'(idx));
    check({tag, ".resp_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, ".resp_cos"}, resp_cos, exp_cos);
    check({tag, ".resp_sin"}, resp_sin, exp_sin);
    step();
    check({tag, ".valid_drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen_valid;
    rst        = 1'b1;
    req        = '0;
    req_angle  = '0;
    resp_ready = 1'b1;
    step();
    step();
    check("rst.gnt",        32'(gnt), 32'd0);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_err",   32'(resp_err), 32'd0);
    check("rst.resp_id",    32'(resp_id), 32'd0);
    check("rst.resp_cos",   resp_cos, 32'd0);
    check("rst.resp_sin",   resp_sin, 32'd0);
    check("rst.core_angle", core_angle, 32'd0);
    rst = 1'b0;
    step();

    run_one("q1_90",    0, 32'd5898240,  17, 32'h005A_0000, 32'h0000_0000, 32'h0001_0000, 1'b0);
    run_one("q2_180",   1, 32'd11796480, 17, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b0);
    run_one("err_360",  2, 32'd23592960,  1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    run_one("q3_270",   3, 32'd17694720, 17, 32'h005A_0000, 32'h0000_0000, 32'hFFFF_0000, 1'b0);
    run_one("sat_neg",  0, 32'd16000000, 17, 32'h0040_2400, 32'h7FFF_FFFF, 32'hFFFE_DCBB, 1'b0);
    run_one("top_359",  1, 32'd23592959, 17, 32'hFFFF_FFFF, 32'h0000_1111, 32'h0000_2222, 1'b0);
    run_one("q4",       2, 32'd20000000, 17, 32'hFFC9_2D00, 32'h0000_1111, 32'h0000_2222, 1'b0);
    run_one("above_90", 3, 32'd5898241,  17, 32'hFFA6_0001, 32'hFFFF_EEEF, 32'hFFFF_DDDE, 1'b0);

    // Round robin with all four requesting continuously
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_angle = '0;
    req = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (gnt == 4'b0 && n < 100) begin
        step();
        n++;
      end
      check("rr.order", 32'(gnt), 32'(1 << (k % 4)));
      step();
      check("rr.no_regrant", 32'(gnt), 32'd0);
    end
    req = '0;
    n = 0;
    while (!resp_valid && n < 40) begin
      step();
      n++;
    end
    check("rr.drain", 32'(resp_valid), 32'd1);
    step();

    // Back-pressure: response held while consumer stalls, no grant meanwhile
    resp_ready = 1'b0;
    req_angle[31:0]   = 32'd5898240;
    req_angle[127:96] = 32'd0;
    req = 4'b1001;
    #1;
    check("stall.gnt", 32'(gnt), 32'b1000);
    step();
    n = 1;
    while (!resp_valid && n < 40) begin
      step();
      n++;
    end
    check("stall.latency", 32'(n), 32'd17);
    for (int k = 0; k < 10; k++) begin
      step();
      check("stall.valid", 32'(resp_valid), 32'd1);
      check("stall.no_gnt", 32'(gnt), 32'd0);
      check("stall.cos", resp_cos, 32'h0001_0000);
      check("stall.id", 32'(resp_id), 32'd3);
    end
    resp_ready = 1'b1;
    step();
    check("stall.release_valid", 32'(resp_valid), 32'd0);
    check("stall.next_gnt", 32'(gnt), 32'b0001);
    step();
    req = '0;
    check("abort.core_angle_set", core_angle, 32'h005A_0000);
    for (int k = 0; k < 5; k++) step();

    // Reset in the middle of RUN discards the operation
    rst = 1'b1;
    step();
    check("abort.valid",      32'(resp_valid), 32'd0);
    check("abort.gnt",        32'(gnt), 32'd0);
    check("abort.core_angle", core_angle, 32'd0);
    check("abort.resp_cos",   resp_cos, 32'd0);
    check("abort.resp_id",    32'(resp_id), 32'd0);
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (resp_valid) seen_valid++;
    end
    check("abort.never_valid", 32'(seen_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
